const_rom_reader: RTL and testbench



---
 rtl/const_rom_reader.sv | 107 ++++++++++
 tb/tb_const_rom_reader.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/const_rom_reader.sv
// Read controller for the four byte-lane SHA-256 constant EEPROMs.
// Fetches single words or bursts of H/K constants and presents them over VALID/ACK.
module const_rom_reader #(
  parameter int unsigned WAIT_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        sel,
  input  logic [5:0]  idx,
  input  logic [6:0]  len,
  output logic        busy,
  output logic [31:0] dout,
  output logic        valid,
  input  logic        ack,
  output logic [12:0] rom_a,
  output logic        rom_ce_n,
  output logic        rom_oe_n,
  output logic        rom_we_n,
  input  logic [7:0]  rom_d1,
  input  logic [7:0]  rom_d2,
  input  logic [7:0]  rom_d3,
  input  logic [7:0]  rom_d4
);

  localparam int unsigned AW = 13;
  localparam int unsigned CW = 4;
  localparam int unsigned LW = 7;

  typedef enum logic [1:0] {IDLE, ACCESS, OUT} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] addr_d;
  logic [CW-1:0] wait_q, wait_d;
  logic [LW-1:0] left_q, left_d;
  logic          capture;

  // Read-only device: write enable is never asserted.
  assign rom_we_n = 1'b1;

  // Next-state logic; address, wait count and words-remaining follow the state.
  always_comb begin
    state_d = state_q;
    addr_d  = rom_a;
    wait_d  = wait_q;
    left_d  = left_q;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (req && (len != '0)) begin
          state_d = ACCESS;
          addr_d  = sel ? (AW'(idx) + AW'(8)) : AW'(idx[2:0]);
          left_d  = len;
          wait_d  = CW'(WAIT_CYCLES);
        end
      end
      ACCESS: begin
        if (wait_q <= CW'(1)) begin
          capture = 1'b1;
          left_d  = left_q - LW'(1);
          wait_d  = '0;
          state_d = OUT;
        end else begin
          wait_d = wait_q - CW'(1);
        end
      end
      OUT: begin
        if (ack) begin
          if (left_q != '0) begin
            addr_d  = rom_a + AW'(1);
            wait_d  = CW'(WAIT_CYCLES);
            state_d = ACCESS;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; status and enables are registered from the next state so they stay glitch-free.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      rom_a    <= '0;
      wait_q   <= '0;
      left_q   <= '0;
      dout     <= '0;
      busy     <= 1'b0;
      valid    <= 1'b0;
      rom_ce_n <= 1'b1;
      rom_oe_n <= 1'b1;
    end else begin
      state_q  <= state_d;
      rom_a    <= addr_d;
      wait_q   <= wait_d;
      left_q   <= left_d;
      if (capture) dout <= {rom_d1, rom_d2, rom_d3, rom_d4};
      busy     <= (state_d != IDLE);
      valid    <= (state_d == OUT);
      rom_ce_n <= (state_d != ACCESS);
      rom_oe_n <= (state_d != ACCESS);
    end
  end

endmodule

// File: tb/tb_const_rom_reader.sv
// Bench for const_rom_reader: EEPROM model, timestamp-based reference model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_const_rom_reader;

  localparam int W = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        sel = 1'b0;
  logic [5:0]  idx = '0;
  logic [6:0]  len = '0;
  logic        ack = 1'b0;
  logic        busy, valid, rom_ce_n, rom_oe_n, rom_we_n;
  logic [31:0] dout;
  logic [12:0] rom_a;
  logic [7:0]  rom_d1, rom_d2, rom_d3, rom_d4;
  logic [31:0] rom_word;

  int vectors = 0;
  int miscompares = 0;

  const_rom_reader #(.WAIT_CYCLES(W)) dut (
    .clk(clk), .rst(rst), .req(req), .sel(sel), .idx(idx), .len(len),
    .busy(busy), .dout(dout), .valid(valid), .ack(ack),
    .rom_a(rom_a), .rom_ce_n(rom_ce_n), .rom_oe_n(rom_oe_n), .rom_we_n(rom_we_n),
    .rom_d1(rom_d1), .rom_d2(rom_d2), .rom_d3(rom_d3), .rom_d4(rom_d4)
  );

  always #5 clk = ~clk;

  // H0..H7 at addresses 0..7, K0..K63 at 8..71.
  logic [31:0] rom_mem [0:71] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a, 32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19,
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] const_at(input logic [12:0] a);
    if (a < 13'd72) return rom_mem[a[6:0]];
    return 32'hffffffff;
  endfunction

  // EEPROM drives garbage unless both enables are low.
  always_comb begin
    rom_word = 32'hdeadbeef;
    if (!rom_ce_n && !rom_oe_n) rom_word = const_at(rom_a);
  end
  assign {rom_d1, rom_d2, rom_d3, rom_d4} = rom_word;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a word becomes valid W cycles after its access begins.
  int          cyc = 0;
  int          m_ready = 0;
  bit          started = 1'b0;
  logic        m_busy = 1'b0;
  logic        m_valid = 1'b0;
  logic [31:0] m_dout = '0;
  logic [12:0] m_addr = '0;
  int          m_left = 0;

  always @(posedge clk) begin
    cyc++;
    started = 1'b1;
    if (rst) begin
      m_busy = 1'b0; m_valid = 1'b0; m_dout = '0; m_addr = '0; m_left = 0;
    end else if (!m_busy) begin
      if (req && len != 0) begin
        m_busy  = 1'b1;
        m_addr  = sel ? 13'(8 + int'(idx)) : 13'(int'(idx) % 8);
        m_left  = int'(len);
        m_ready = cyc + W;
      end
    end else if (!m_valid) begin
      if (cyc == m_ready) begin
        m_valid = 1'b1;
        m_dout  = const_at(m_addr);
        m_left  = m_left - 1;
      end
    end else if (ack) begin
      m_valid = 1'b0;
      if (m_left == 0) begin
        m_busy = 1'b0;
      end else begin
        m_addr  = m_addr + 13'd1;
        m_ready = cyc + W;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (started) begin
      check("busy", 32'(busy), 32'(m_busy));
      check("valid", 32'(valid), 32'(m_valid));
      check("dout", dout, m_dout);
      check("rom_a", 32'(rom_a), 32'(m_addr));
      check("ce_n", 32'(rom_ce_n), 32'(!(m_busy && !m_valid)));
      check("oe_n", 32'(rom_oe_n), 32'(!(m_busy && !m_valid)));
      check("we_n", 32'(rom_we_n), 32'd1);
    end
  end

  task automatic send(input logic s, input logic [5:0] i, input logic [6:0] l);
    @(negedge clk);
    req = 1'b1; sel = s; idx = i; len = l;
  endtask

  // Counts negedges until VALID appears; bounded so a stuck DUT still reaches the summary.
  task automatic wait_valid(input string name, input int exp_n);
    int n = 0;
    do begin
      @(negedge clk);
      req = 1'b0;
      n++;
    end while (!valid && n < 60);
    check({name, "_latency"}, 32'(n), 32'(exp_n));
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_dout", dout, 32'h0);
    check("rst_rom_a", 32'(rom_a), 32'd0);
    check("rst_ce_oe_we", {29'd0, rom_ce_n, rom_oe_n, rom_we_n}, 32'h7);

    // H[0], single word, ACK tied high
    ack = 1'b1;
    send(1'b0, 6'd0, 7'd1);
    @(negedge clk); req = 1'b0;
    check("h0_access_addr", 32'(rom_a), 32'd0);
    check("h0_access_ce", 32'(rom_ce_n), 32'd0);
    begin
      int n = 1;
      while (!valid && n < 60) begin @(negedge clk); n++; end
      check("h0_latency", 32'(n), 32'(W + 1));
    end
    check("h0_dout", dout, 32'h6a09e667);
    @(negedge clk);
    check("h0_valid_one_cycle", 32'(valid), 32'd0);
    check("h0_busy_drop", 32'(busy), 32'd0);

    // K[0] with ten cycles of backpressure
    ack = 1'b0;
    send(1'b1, 6'd0, 7'd1);
    wait_valid("k0", W + 1);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("k0_hold_valid", 32'(valid), 32'd1);
      check("k0_hold_dout", dout, 32'h428a2f98);
      check("k0_hold_enables", {30'd0, rom_ce_n, rom_oe_n}, 32'h3);
    end
    ack = 1'b1;
    @(negedge clk);
    check("k0_idle_after_ack", 32'(busy), 32'd0);

    // K[62..63] burst
    send(1'b1, 6'd62, 7'd2);
    wait_valid("k62", W + 1);
    check("k62_dout", dout, 32'hbef9a3f7);
    check("k62_addr", 32'(rom_a), 32'd70);
    wait_valid("k63", W + 1);
    check("k63_dout", dout, 32'hc67178f2);
    check("k63_addr", 32'(rom_a), 32'd71);
    @(negedge clk);
    check("k62_burst_done", 32'(busy), 32'd0);

    // H[6], H[7], then into K[0]
    send(1'b0, 6'd6, 7'd3);
    wait_valid("h6", W + 1);
    check("h6_dout", dout, 32'h1f83d9ab);
    wait_valid("h7", W + 1);
    check("h7_dout", dout, 32'h5be0cd19);
    wait_valid("hk", W + 1);
    check("hk_dout", dout, 32'h428a2f98);
    check("hk_addr", 32'(rom_a), 32'd8);
    @(negedge clk);

    // Reset during the third word's access of an 8-word K burst
    send(1'b1, 6'd0, 7'd8);
    wait_valid("rb0", W + 1);
    wait_valid("rb1", W + 1);
    check("rb1_dout", dout, 32'h71374491);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rb_valid", 32'(valid), 32'd0);
    check("rb_dout", dout, 32'h0);
    check("rb_enables", {30'd0, rom_ce_n, rom_oe_n}, 32'h3);
    check("rb_busy", 32'(busy), 32'd0);
    repeat (8) @(negedge clk);
    check("rb_no_word", 32'(valid), 32'd0);
    send(1'b1, 6'd1, 7'd1);
    wait_valid("k1", W + 1);
    check("k1_dout", dout, 32'h71374491);
    @(negedge clk);

    // LEN = 0 is ignored
    send(1'b0, 6'd3, 7'd0);
    repeat (3) begin
      @(negedge clk); req = 1'b0;
      check("len0_busy", 32'(busy), 32'd0);
    end

    // REQ pulse during OUT changes nothing
    ack = 1'b0;
    send(1'b1, 6'd5, 7'd1);
    wait_valid("k5", W + 1);
    check("k5_dout", dout, 32'h59f111f1);
    req = 1'b1; sel = 1'b0; idx = 6'd0; len = 7'd3;
    @(negedge clk); req = 1'b0;
    check("k5_dout_after_req", dout, 32'h59f111f1);
    check("k5_valid_after_req", 32'(valid), 32'd1);
    ack = 1'b1;
    @(negedge clk);
    check("k5_done", 32'(busy), 32'd0);
    repeat (10) @(negedge clk);
    check("k5_no_extra", 32'(valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule
